// File: rtl/sram_device_model_if.sv
// Control/address pins of the 16-bit external SRAM interface.
// The controller (master) drives every signal here and the device model
// (slave) only samples them. SRAM_DQ is not part of this bundle. It is a
// resolved tristate net shared by both ends, so it stays a module-level
// inout wire that is connected to a plain net.
//   SRAM_ADDR  halfword address
//   SRAM_UB_N  upper byte lane enable, active low
//   SRAM_LB_N  lower byte lane enable, active low
//   SRAM_WE_N  write enable, active low
//   SRAM_CE_N  chip enable, active low
//   SRAM_OE_N  output enable, active low
interface sram_device_model_if;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;
  logic        SRAM_WE_N;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;

  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input  SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_device_model.sv
// Clocked stand-in for an external 16-bit SRAM chip. It stores byte-laned
// writes and returns read data on SRAM_DQ after READ_LAT clocks. It also
// keeps read/write access counters and a sticky flag that records an illegal
// pin combination (WE_N and OE_N low at the same time).
//   clk        rising-edge clock
//   rst        synchronous active-high reset; the array contents are kept
//   bus        control/address pins (slave side)
//   SRAM_DQ    bidirectional data; driven only while a qualified read is output
//   rd_count   qualified read cycles since reset (wraps)
//   wr_count   qualified write cycles since reset (wraps)
//   proto_err  sticky contention flag
module sram_device_model #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_device_model_if.slave   bus,
  inout  wire  [15:0]          SRAM_DQ,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic                 proto_err
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam int unsigned OUT_STG = READ_LAT - 1;

  // Reject parameter values the pipeline and address slice cannot support.
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("sram_device_model: READ_LAT must be 1..4");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 18) begin : g_bad_addr
    $error("sram_device_model: ADDR_BITS must be 1..18");
  end

  // Address bits above the implemented depth alias and are ignored.
  if (ADDR_BITS < 18) begin : g_addr_hi
    logic unused_addr_c;
    assign unused_addr_c = ^bus.SRAM_ADDR[17:ADDR_BITS];
  end

  // The array starts zeroed at time zero, and reset does not clear it.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic [ADDR_BITS-1:0] idx_c;
  logic                 sel_c;
  logic                 wr_cyc_c;
  logic                 rd_cyc_c;
  logic                 clash_c;

  // Decode the cycle type from the pins sampled at this edge.
  always_comb begin
    idx_c    = bus.SRAM_ADDR[ADDR_BITS-1:0];
    sel_c    = ~bus.SRAM_CE_N;
    wr_cyc_c = sel_c & ~bus.SRAM_WE_N & (~bus.SRAM_UB_N | ~bus.SRAM_LB_N);
    rd_cyc_c = sel_c &  bus.SRAM_WE_N & ~bus.SRAM_OE_N;
    clash_c  = sel_c & ~bus.SRAM_WE_N & ~bus.SRAM_OE_N;
  end

  logic [READ_LAT-1:0]             vld_q,  vld_d;
  logic [READ_LAT-1:0]             ub_n_q, ub_n_d;
  logic [READ_LAT-1:0]             lb_n_q, lb_n_d;
  logic [READ_LAT-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]            rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]            wr_cnt_q, wr_cnt_d;
  logic                            perr_q, perr_d;

  // Read pipeline shift, counters and the sticky error flag.
  always_comb begin
    vld_d    = vld_q;
    ub_n_d   = ub_n_q;
    lb_n_d   = lb_n_q;
    data_d   = data_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    perr_d   = perr_q;

    for (int i = 1; i < int'(READ_LAT); i++) begin
      vld_d[i]  = vld_q[i-1];
      ub_n_d[i] = ub_n_q[i-1];
      lb_n_d[i] = lb_n_q[i-1];
      data_d[i] = data_q[i-1];
    end
    // Stage 0 always captures. Only the valid bit decides whether the data is used.
    vld_d[0]  = rd_cyc_c;
    ub_n_d[0] = bus.SRAM_UB_N;
    lb_n_d[0] = bus.SRAM_LB_N;
    data_d[0] = mem_q[idx_c];

    rd_cnt_d = rd_cnt_q + CNT_WIDTH'(rd_cyc_c);
    wr_cnt_d = wr_cnt_q + CNT_WIDTH'(wr_cyc_c);
    perr_d   = perr_q | clash_c;
  end

  // Control state resets. The pipeline payload does not need a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      perr_q   <= perr_d;
    end
    ub_n_q <= ub_n_d;
    lb_n_q <= lb_n_d;
    data_q <= data_d;
  end

  // Byte-laned array write. Reset takes priority over a write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_cyc_c) begin
      if (!bus.SRAM_UB_N) mem_q[idx_c][15:8] <= SRAM_DQ[15:8];
      if (!bus.SRAM_LB_N) mem_q[idx_c][7:0]  <= SRAM_DQ[7:0];
    end
  end

  logic [DATA_W-1:0] out_data_c;
  logic              gate_c;
  logic              hi_en_c;
  logic              lo_en_c;

  // Lane drive is gated by the live pins. WE_N low turns the drive off immediately.
  always_comb begin
    out_data_c = data_q[OUT_STG];
    gate_c     = vld_q[OUT_STG] & sel_c & bus.SRAM_WE_N & ~bus.SRAM_OE_N;
    hi_en_c    = gate_c & ~ub_n_q[OUT_STG];
    lo_en_c    = gate_c & ~lb_n_q[OUT_STG];
  end

  assign SRAM_DQ = {hi_en_c ? out_data_c[15:8] : 8'hzz,
                    lo_en_c ? out_data_c[7:0]  : 8'hzz};

  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_sram_device_model.sv
// Directed bench for sram_device_model. Instance A uses the default
// parameters (READ_LAT=1). Instance B uses READ_LAT=3 and a 4-bit counter so
// that counter wrap is exercised. The DQ nets are tri1, so an undriven lane
// reads back as 8'hFF.
module tb_sram_device_model;

  logic clk;
  logic rst_a, rst_b;

  sram_device_model_if sif_a ();
  sram_device_model_if sif_b ();

  tri1 [15:0] dq_a;
  tri1 [15:0] dq_b;
  logic [15:0] tb_dq_a, tb_dq_b;
  logic        tb_oe_a, tb_oe_b;
  assign dq_a = tb_oe_a ? tb_dq_a : 16'hzzzz;
  assign dq_b = tb_oe_b ? tb_dq_b : 16'hzzzz;

  logic [15:0] cnt_rd_a, cnt_wr_a;
  logic        perr_a;
  logic [3:0]  cnt_rd_b, cnt_wr_b;
  logic        perr_b;

  sram_device_model u_dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .bus       (sif_a),
    .SRAM_DQ   (dq_a),
    .rd_count  (cnt_rd_a),
    .wr_count  (cnt_wr_a),
    .proto_err (perr_a)
  );

  sram_device_model #(.ADDR_BITS(10), .READ_LAT(3), .CNT_WIDTH(4)) u_dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .bus       (sif_b),
    .SRAM_DQ   (dq_b),
    .rd_count  (cnt_rd_b),
    .wr_count  (cnt_wr_b),
    .proto_err (perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model and scoreboard.
  logic [15:0] mdl_a [1024];
  logic [15:0] mdl_b [1024];
  logic [15:0] exp_rd_a, exp_wr_a;
  logic        exp_perr_a;
  logic [3:0]  exp_rd_b, exp_wr_b;
  logic        exp_perr_b;
  logic [15:0] q_a [$];
  logic [15:0] q_b [$];
  int          total;
  int          bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] lanes(input logic [15:0] m, input logic ub_n, input logic lb_n);
    return {ub_n ? 8'hFF : m[15:8], lb_n ? 8'hFF : m[7:0]};
  endfunction

  task automatic pins_a(input logic ce, we, oe, ub, lb, input logic [17:0] addr);
    sif_a.SRAM_CE_N = ce; sif_a.SRAM_WE_N = we; sif_a.SRAM_OE_N = oe;
    sif_a.SRAM_UB_N = ub; sif_a.SRAM_LB_N = lb; sif_a.SRAM_ADDR = addr;
  endtask

  task automatic pins_b(input logic ce, we, oe, ub, lb, input logic [17:0] addr);
    sif_b.SRAM_CE_N = ce; sif_b.SRAM_WE_N = we; sif_b.SRAM_OE_N = oe;
    sif_b.SRAM_UB_N = ub; sif_b.SRAM_LB_N = lb; sif_b.SRAM_ADDR = addr;
  endtask

  task automatic idle_a();
    pins_a(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0);
    tb_oe_a = 1'b0;
  endtask

  task automatic idle_b();
    pins_b(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0);
    tb_oe_b = 1'b0;
  endtask

  task automatic cnt_a(input string tag);
    chk({tag, "_rd_count"}, 32'(cnt_rd_a), 32'(exp_rd_a));
    chk({tag, "_wr_count"}, 32'(cnt_wr_a), 32'(exp_wr_a));
    chk({tag, "_proto_err"}, 32'(perr_a), 32'(exp_perr_a));
  endtask

  task automatic cnt_b(input string tag);
    chk({tag, "_rd_count"}, 32'(cnt_rd_b), 32'(exp_rd_b));
    chk({tag, "_wr_count"}, 32'(cnt_wr_b), 32'(exp_wr_b));
    chk({tag, "_proto_err"}, 32'(perr_b), 32'(exp_perr_b));
  endtask

  task automatic wr_a_t(input logic [17:0] addr, input logic [15:0] data, input logic ub, lb);
    pins_a(1'b0, 1'b0, 1'b1, ub, lb, addr);
    tb_dq_a = data;
    tb_oe_a = 1'b1;
    if (!ub) mdl_a[addr[9:0]][15:8] = data[15:8];
    if (!lb) mdl_a[addr[9:0]][7:0]  = data[7:0];
    if (!(ub && lb)) exp_wr_a++;
    step();
    idle_a();
  endtask

  task automatic rd_a_t(input logic [17:0] addr, input logic ub, lb, oe_off, input string tag);
    pins_a(1'b0, 1'b1, 1'b0, ub, lb, addr);
    q_a.push_back(lanes(mdl_a[addr[9:0]], ub, lb));
    exp_rd_a++;
    step();
    chk(tag, 32'(dq_a), 32'(q_a.pop_front()));
    if (oe_off) begin
      sif_a.SRAM_OE_N = 1'b1;
      #1;
      chk({tag, "_oe_off"}, 32'(dq_a), 32'h0000_FFFF);
    end
    idle_a();
  endtask

  task automatic wr_b_t(input logic [17:0] addr, input logic [15:0] data);
    pins_b(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, addr);
    tb_dq_b = data;
    tb_oe_b = 1'b1;
    mdl_b[addr[9:0]] = data;
    exp_wr_b++;
    step();
    idle_b();
  endtask

  // Holds the read pins for n+2 edges. With latency 3, the output at edge i comes from capture i-2.
  task automatic stream_b(input int n, input logic [17:0] base, input string tag);
    for (int i = 0; i < n + 2; i++) begin
      logic [17:0] a;
      a = (i < n) ? base + 18'(i) : base;
      pins_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a);
      q_b.push_back(mdl_b[a[9:0]]);
      exp_rd_b++;
      step();
      if (i >= 2) chk(tag, 32'(dq_b), 32'(q_b.pop_front()));
    end
    idle_b();
    q_b.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) begin
      mdl_a[i] = 16'h0000;
      mdl_b[i] = 16'h0000;
    end
    exp_rd_a = '0; exp_wr_a = '0; exp_perr_a = 1'b0;
    exp_rd_b = '0; exp_wr_b = '0; exp_perr_b = 1'b0;
    tb_dq_a = '0; tb_dq_b = '0;
    idle_a();
    idle_b();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) step();
    rst_a = 1'b0;
    rst_b = 1'b0;

    cnt_a("a_reset");
    cnt_b("b_reset");
    chk("a_reset_dq", 32'(dq_a), 32'h0000_FFFF);

    // Basic write, then a latency-1 read.
    wr_a_t(18'd5, 16'h1234, 1'b0, 1'b0);
    rd_a_t(18'd5, 1'b0, 1'b0, 1'b0, "t1_read");
    cnt_a("t1");

    // Partial-lane write merges with the old upper byte.
    wr_a_t(18'd7, 16'hAAAA, 1'b0, 1'b0);
    wr_a_t(18'd7, 16'h55FF, 1'b1, 1'b0);
    rd_a_t(18'd7, 1'b0, 1'b0, 1'b0, "t2_merge");

    // Lane-masked reads and OE_N gating.
    rd_a_t(18'd7, 1'b1, 1'b0, 1'b1, "t3_lb_only");
    rd_a_t(18'd5, 1'b1, 1'b0, 1'b0, "t3_lo_lane");
    rd_a_t(18'd5, 1'b0, 1'b1, 1'b0, "t3_hi_lane");

    // Address aliasing modulo 1024.
    wr_a_t(18'h00400, 16'hBEEF, 1'b0, 1'b0);
    rd_a_t(18'h00000, 1'b0, 1'b0, 1'b0, "t4_alias");

    // Write with both lanes disabled does nothing.
    wr_a_t(18'd9, 16'h1111, 1'b0, 1'b0);
    wr_a_t(18'd9, 16'h7777, 1'b1, 1'b1);
    rd_a_t(18'd9, 1'b0, 1'b0, 1'b0, "null_wr_data");
    cnt_a("null_wr");

    // Contention: the write lands, no read is captured, and the error flag latches.
    pins_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd3);
    tb_dq_a = 16'h0F0F;
    tb_oe_a = 1'b1;
    mdl_a[3] = 16'h0F0F;
    exp_wr_a++;
    exp_perr_a = 1'b1;
    step();
    idle_a();
    cnt_a("t5_clash");
    rd_a_t(18'd3, 1'b0, 1'b0, 1'b0, "t5_data");
    cnt_a("t5_sticky");

    // CE_N high: the read pins are ignored.
    pins_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'd5);
    step();
    chk("ce_off_dq", 32'(dq_a), 32'h0000_FFFF);
    idle_a();
    cnt_a("ce_off");

    // Write pins on a reset edge: the reset wins and the array is unchanged.
    pins_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd5);
    tb_dq_a = 16'hDEAD;
    tb_oe_a = 1'b1;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    idle_a();
    exp_rd_a = '0; exp_wr_a = '0; exp_perr_a = 1'b0;
    cnt_a("rst_cnt");
    rd_a_t(18'd5, 1'b0, 1'b0, 1'b0, "rst_no_wr");

    // Instance B: 16 writes wrap the 4-bit write counter.
    for (int i = 0; i < 16; i++) wr_b_t(18'(i), 16'hC000 + 16'(i) * 16'h0101);
    chk("b_wr_wrap", 32'(cnt_wr_b), 32'(exp_wr_b));
    stream_b(16, 18'd0, "b_stream");
    chk("b_rd_wrap", 32'(cnt_rd_b), 32'(exp_rd_b));

    // Contention on instance B.
    pins_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd3);
    tb_dq_b = 16'h0F0F;
    tb_oe_b = 1'b1;
    mdl_b[3] = 16'h0F0F;
    exp_wr_b++;
    exp_perr_b = 1'b1;
    step();
    idle_b();
    cnt_b("b_clash");

    // A read in flight is dropped by the reset on the following edge.
    pins_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd3);
    step();
    idle_b();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    exp_rd_b = '0; exp_wr_b = '0; exp_perr_b = 1'b0;
    cnt_b("t6_rst");
    pins_b(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd5);
    step();
    chk("t6_dq_undriven", 32'(dq_b), 32'h0000_FFFF);
    exp_rd_b = 4'd1;
    chk("t6_rd_count", 32'(cnt_rd_b), 32'(exp_rd_b));
    idle_b();
    stream_b(1, 18'd3, "t6_mem_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
